// File: rtl/chunked_adder_pkg.sv
// rtl/chunked_adder_pkg.sv - shared types and helpers for the chunked adder
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk counter width. Clamped to 1 so a single-chunk build still has a
  // real (if trivially constant) counter register.
  function automatic int cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// rtl/chunk_add.sv - combinational W-bit adder slice with carry-in/out
// Ports:
//   a, b  : W-bit addends
//   cin   : carry-in
//   s     : W-bit sum
//   cout  : carry-out of the slice MSB
module chunk_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle adder summing CHUNK bits per clock
// Optional feature macro: CHUNKED_ADDER_OVF_EN adds the ovf port and logic.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin)
//   out_valid / out_ready : result handshake (sum, cout[, ovf])
//   sum  : a + b + cin modulo 2^WIDTH
//   cout : carry out of the MSB
//   ovf  : signed overflow (only with CHUNKED_ADDER_OVF_EN)
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_chunk;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)           next_state = ADD;
      ADD:     if (cnt_q == LAST_CNT)  next_state = DONE;
      DONE:    if (out_ready)          next_state = IDLE;
      default:                         next_state = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Select the active operand slice; a mux over chunk indices keeps the
  // selection free of variable part-select arithmetic.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_add #(.W(CHUNK)) u_chunk_add (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .s    (s_chunk),
    .cout (c_chunk)
  );

`ifdef CHUNKED_ADDER_OVF_EN
  logic ovf_q;
`endif

  // Datapath registers. Operands are captured at acceptance so the producer
  // may change a/b afterwards; results hold through DONE until the next op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        ADD: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CNT_W'(i)) sum_q[i*CHUNK +: CHUNK] <= s_chunk;
          end
          carry_q <= c_chunk;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            cout_q <= c_chunk;
`ifdef CHUNKED_ADDER_OVF_EN
            // The last chunk carries the MSB, so its fresh sum bit is the
            // result sign used for the overflow test.
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (s_chunk[CHUNK-1] != a_q[WIDTH-1]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef CHUNKED_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// tb/tb_chunked_adder.sv - self-checking bench for chunked_adder (32/8 and 8/8 builds)
module tb_chunked_adder;

  localparam int W32 = 32;
  localparam int W8  = 8;
  localparam int LAT32 = W32 / 8;
  localparam int LAT8  = 1;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           cin;
  logic           out_ready;
  logic [W32-1:0] a, b;
  logic [W8-1:0]  a8, b8;
  logic           in_ready, out_valid, cout;
  logic [W32-1:0] sum;
  logic           in_ready8, out_valid8, cout8;
  logic [W8-1:0]  sum8;
`ifdef CHUNKED_ADDER_OVF_EN
  logic           ovf, ovf8;
`endif

  int checks = 0;
  int errors = 0;

  chunked_adder #(.WIDTH(W32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  chunked_adder #(.WIDTH(W8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin), .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .cout(cout8)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation presented to both builds at once; the 8-bit build sees
  // the low byte of each operand.
  task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic cin_i, input int hold);
    logic [32:0] r32;
    logic [8:0]  r8;
    int lat, lat8, k;
    r32 = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
    r8  = {1'b0, a_i[7:0]} + {1'b0, b_i[7:0]} + {8'd0, cin_i};

    @(negedge clk);
    a = a_i; b = b_i; a8 = a_i[7:0]; b8 = b_i[7:0]; cin = cin_i; in_valid = 1'b1;
    check("in_ready_idle32", in_ready, 1'b1);
    check("in_ready_idle8", in_ready8, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; a8 = 8'($urandom); b8 = 8'($urandom); cin = 1'($urandom);

    k = 0; lat = -1; lat8 = -1;
    while ((lat < 0 || lat8 < 0) && k <= 20) begin
      if (out_valid  && lat  < 0) lat  = k;
      if (out_valid8 && lat8 < 0) lat8 = k;
      if (lat < 0 || lat8 < 0) begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("latency32", 64'(lat), 64'(LAT32));
    check("latency8", 64'(lat8), 64'(LAT8));
    check("sum32", sum, r32[31:0]);
    check("cout32", cout, r32[32]);
    check("sum8", sum8, r8[7:0]);
    check("cout8", cout8, r8[8]);
`ifdef CHUNKED_ADDER_OVF_EN
    check("ovf32", ovf, (a_i[31] == b_i[31]) && (r32[31] != a_i[31]));
    check("ovf8", ovf8, (a_i[7] == b_i[7]) && (r8[7] != a_i[7]));
`endif

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = (h % 2 == 0);
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      check("hold_valid32", out_valid, 1'b1);
      check("hold_sum32", sum, r32[31:0]);
      check("hold_cout32", cout, r32[32]);
      check("hold_in_ready32", in_ready, 1'b0);
      check("hold_valid8", out_valid8, 1'b1);
      check("hold_sum8", sum8, r8[7:0]);
      check("hold_in_ready8", in_ready8, 1'b0);
    end

    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid32", out_valid, 1'b0);
    check("drain_in_ready32", in_ready, 1'b1);
    check("drain_valid8", out_valid8, 1'b0);
    check("drain_in_ready8", in_ready8, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'd0);
    check("rst_cout", cout, 1'b0);
    check("rst_out_valid8", out_valid8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    do_op(32'h12345678, 32'h11111111, 1'b1, 0);
    do_op($urandom, $urandom, 1'($urandom), 5);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
    do_op(32'h80000000, 32'h80000000, 1'b0, 0);
    do_op(32'h000000FF, 32'h00000001, 1'b1, 0);

    // Reset two cycles into ADD discards the op immediately.
    @(negedge clk);
    a = $urandom; b = $urandom; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_sum", sum, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("postrst_out_valid", out_valid, 1'b0);
    do_op(32'h00000005, 32'h00000007, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      do_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
